// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine (shift-add multiply, restoring divide).
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies finish via a combinational product in FIX.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            MD_start,
  input  logic [2:0]      MD_funct3,
  input  logic [XLEN-1:0] MD_rs1_data,
  input  logic [XLEN-1:0] MD_rs2_data,
  output logic            MD_busy,
  output logic            MD_done,
  output logic [XLEN-1:0] MD_result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic            fast_q;
  logic [XLEN-1:0] fast_res_q;
  logic [XLEN-1:0] opb_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN:0]   acc_hi_q;  // product high half / partial remainder
  logic [XLEN-1:0] acc_lo_q;  // multiplier / dividend shifting into quotient
  logic [CW-1:0]   cnt_q;

  // Acceptance-time decode of the incoming request
  logic            sa, sb, a_neg, b_neg, res_neg, div_zero, div_ovf, take_fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    sa       = MD_funct3[2] ? ~MD_funct3[0] : (MD_funct3[1:0] != 2'b11);
    sb       = MD_funct3[2] ? ~MD_funct3[0] : ~MD_funct3[1];
    a_neg    = sa & MD_rs1_data[XLEN-1];
    b_neg    = sb & MD_rs2_data[XLEN-1];
    mag_a    = a_neg ? -MD_rs1_data : MD_rs1_data;
    mag_b    = b_neg ? -MD_rs2_data : MD_rs2_data;
    res_neg  = (MD_funct3[2] & MD_funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = MD_funct3[2] & (MD_rs2_data == '0);
    div_ovf  = MD_funct3[2] & ~MD_funct3[0] & (MD_rs1_data == MIN_INT) & (MD_rs2_data == '1);
    fast_res = '0;
    if (div_zero)     fast_res = MD_funct3[1] ? MD_rs1_data : '1;
    else if (div_ovf) fast_res = MD_funct3[1] ? '0 : MD_rs1_data;
`ifdef MULDIV_FAST_MUL_EN
    take_fast = div_zero | div_ovf | ~MD_funct3[2];
`else
    take_fast = div_zero | div_ovf;
`endif
  end

  // One CALC cycle: BITS_PER_CYCLE single-bit steps chained combinationally
  logic [XLEN:0]   step_hi;
  logic [XLEN-1:0] step_lo;

  always_comb begin
    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   trial;
    hi    = acc_hi_q;
    lo    = acc_lo_q;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (f3_q[2]) begin
        trial = {hi[XLEN-1:0], lo[XLEN-1]};
        lo    = {lo[XLEN-2:0], 1'b0};
        if (trial >= {1'b0, opb_q}) begin
          trial = trial - {1'b0, opb_q};
          lo[0] = 1'b1;
        end
        hi = trial;
      end else begin
        trial = {1'b0, hi[XLEN-1:0]} + (lo[0] ? {1'b0, opb_q} : '0);
        lo    = {trial[0], lo[XLEN-1:1]};
        hi    = {1'b0, trial[XLEN:1]};
      end
    end
    step_hi = hi;
    step_lo = lo;
  end

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, div_res, mul_res, fix_result;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = {{XLEN{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_lo_q};
`else
    prod = {acc_hi_q[XLEN-1:0], acc_lo_q};
`endif
    prod_s     = neg_q ? -prod : prod;
    mul_res    = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo        = acc_lo_q;
    rem        = acc_hi_q[XLEN-1:0];
    div_res    = f3_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);
    fix_result = f3_q[2] ? (fast_q ? fast_res_q : div_res) : mul_res;
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q    <= S_IDLE;
      MD_busy    <= 1'b0;
      MD_done    <= 1'b0;
      MD_result  <= '0;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      opb_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          MD_done <= 1'b0;
          if (MD_start) begin
            f3_q       <= MD_funct3;
            neg_q      <= res_neg;
            fast_q     <= take_fast;
            fast_res_q <= fast_res;
            opb_q      <= MD_funct3[2] ? mag_b : mag_a;
            acc_lo_q   <= MD_funct3[2] ? mag_a : mag_b;
            acc_hi_q   <= '0;
            cnt_q      <= CW'(N);
            MD_busy    <= 1'b1;
            state_q    <= take_fast ? S_FIX : S_CALC;
          end else begin
            MD_busy <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          MD_result <= fix_result;
          MD_busy   <= 1'b0;
          MD_done   <= 1'b1;
          state_q   <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
